fifo_traffic_gen: RTL and testbench

FIFO_TRAFFIC_GEN -- requirements
Module: fifo_traffic_gen

---
 rtl/fifo_traffic_gen.sv | 112 +++++++++++
 tb/tb_fifo_traffic_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: writes an incrementing data burst into a FIFO, reads it back and checks it
module fifo_traffic_gen #(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [3:0]       burst_len,
    input  logic [WIDTH-1:0] seed,
    input  logic             full,
    input  logic             empty,
    input  logic [WIDTH-1:0] rd_data,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             rd_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [3:0]       err_count
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT);

    state_t                  state_q;
    logic [4:0]              n_q, wr_cnt_q, rd_cnt_q, chk_cnt_q, chk_cnt_d;
    logic [WIDTH-1:0]        wr_pat_q, exp_pat_q, exp_pat_d;
    logic [7:0]              stall_q, stall_d;
    logic [3:0]              err_q, err_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic                    pass_q, timeout_q, vld_out, stalled;

    assign busy      = state_q == FILL || state_q == DRAIN;
    assign done      = state_q == DONE;
    assign wr_en     = state_q == FILL && ena && !full && wr_cnt_q < n_q;
    assign rd_en     = state_q == DRAIN && ena && !empty && rd_cnt_q < n_q;
    assign wr_data   = wr_pat_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;

    // read-check pipeline and stall watchdog next-state; the check path ignores ena
    always_comb begin
        vld_out   = vld_q[READ_LATENCY-1];
        vld_d     = READ_LATENCY'({vld_q, rd_en});
        err_d     = (vld_out && rd_data != exp_pat_q && err_q != 4'd15) ? err_q + 4'd1 : err_q;
        exp_pat_d = vld_out ? exp_pat_q + WIDTH'(1) : exp_pat_q;
        chk_cnt_d = vld_out ? chk_cnt_q + 5'd1 : chk_cnt_q;
        stall_d   = (wr_en || vld_out) ? 8'd0 : (busy && ena) ? stall_q + 8'd1 : stall_q;
        stalled   = busy && ena && stall_d == STALL_MAX;
    end

    // burst FSM with counters, data patterns and the sticky result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            chk_cnt_q <= '0;
            wr_pat_q  <= '0;
            exp_pat_q <= '0;
            stall_q   <= '0;
            err_q     <= '0;
            vld_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            err_q     <= err_d;
            exp_pat_q <= exp_pat_d;
            chk_cnt_q <= chk_cnt_d;
            stall_q   <= stall_d;
            if (wr_en) begin
                wr_pat_q <= wr_pat_q + WIDTH'(1);
                wr_cnt_q <= wr_cnt_q + 5'd1;
            end
            if (rd_en) rd_cnt_q <= rd_cnt_q + 5'd1;
            if (stalled) begin
                state_q   <= DONE;
                timeout_q <= 1'b1;
                pass_q    <= 1'b0;
                vld_q     <= '0;
            end else if (ena) begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q   <= FILL;
                        n_q       <= {burst_len == 4'd0, burst_len};
                        wr_pat_q  <= seed;
                        exp_pat_q <= seed;
                        wr_cnt_q  <= '0;
                        rd_cnt_q  <= '0;
                        chk_cnt_q <= '0;
                        stall_q   <= '0;
                        err_q     <= '0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                    FILL: if (wr_en && wr_cnt_q == n_q - 5'd1) state_q <= DRAIN;
                    DRAIN: if (chk_cnt_d == n_q) begin
                        state_q <= DONE;
                        pass_q  <= err_d == 4'd0;
                    end
                    DONE: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: drives bursts against an ideal FIFO model and checks the generator's results
module tb_fifo_traffic_gen;
    logic        clk = 1'b0;
    logic        rst_n, ena, start, start8;
    logic [3:0]  burst_len;
    logic [7:0]  seed, rd_data, wr_data, wr_data8;
    logic        full, empty, wr_en, rd_en, busy, done, pass, timeout;
    logic        wr_en8, rd_en8, busy8, done8, pass8, timeout8;
    logic [3:0]  err_count, err_count8;
    logic        force_full, force_empty;
    logic [15:0] cmask;
    int          nchk, nerr, fcnt, pops, pop_base, cyc_n, rd_seen, done_cnt;
    logic [7:0]  fq[$];
    logic [7:0]  wlog[$];
    int          wcyc[$];

    always #5 clk = ~clk;

    fifo_traffic_gen dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .burst_len(burst_len),
        .seed(seed), .full(full), .empty(empty), .rd_data(rd_data), .wr_en(wr_en),
        .wr_data(wr_data), .rd_en(rd_en), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count)
    );

    fifo_traffic_gen #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start8), .burst_len(burst_len),
        .seed(seed), .full(1'b1), .empty(1'b1), .rd_data(8'h00), .wr_en(wr_en8),
        .wr_data(wr_data8), .rd_en(rd_en8), .busy(busy8), .done(done8), .pass(pass8),
        .timeout(timeout8), .err_count(err_count8)
    );

    assign full  = fcnt >= 16 || force_full;
    assign empty = fcnt == 0 || force_empty;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ideal 16-deep FIFO, one cycle read latency; reads flagged in cmask come back inverted
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fcnt    <= 0;
            rd_data <= 8'h00;
        end else begin
            if (rd_en && fq.size() > 0) begin
                rd_data <= cmask[4'(pops - pop_base)] ? ~fq[0] : fq[0];
                void'(fq.pop_front());
                pops++;
            end
            if (wr_en) fq.push_back(wr_data);
            fcnt <= fq.size();
        end
    end

    // strobe legality and write log
    always @(negedge clk) begin
        cyc_n++;
        if (rst_n) begin
            if (wr_en) begin
                chk("wr_legal", {30'd0, ena, full}, 32'd2);
                wlog.push_back(wr_data);
                wcyc.push_back(cyc_n);
            end
            if (rd_en) begin
                chk("rd_legal", {30'd0, ena, empty}, 32'd2);
                rd_seen++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_zero(input string p);
        chk({p, "_wr_en"}, 32'(wr_en), 0);
        chk({p, "_rd_en"}, 32'(rd_en), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_pass"}, 32'(pass), 0);
        chk({p, "_timeout"}, 32'(timeout), 0);
        chk({p, "_err_count"}, 32'(err_count), 0);
        chk({p, "_wr_data"}, 32'(wr_data), 0);
    endtask

    // mode 0 ideal, 1 random stalls/ena, 2 full held mid-fill, 3 ena drop in drain + start while busy, 4 reset mid-drain
    task automatic burst(input int len, input logic [7:0] sd, input logic [15:0] cm, input int mode);
        int n, ec, hc, wb, rb, db, nw;
        bit got;
        logic [15:0] m;
        logic [7:0] e;
        n  = (len == 0) ? 16 : len;
        m  = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
        ec = $countones(cm & m);
        if (ec > 15) ec = 15;
        cyc();
        ena = 1'b1; force_full = 1'b0; force_empty = 1'b0; cmask = cm; pop_base = pops;
        wb = wlog.size(); rb = rd_seen; db = done_cnt;
        burst_len = len[3:0]; seed = sd; start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        got = 0; hc = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (done) got = 1;
            else begin
                if (mode == 2 && force_full) chk("hold_no_wr", 32'(wr_en), 0);
                if (mode == 3 && !ena) begin
                    chk("ena_off_wr", 32'(wr_en), 0);
                    chk("ena_off_rd", 32'(rd_en), 0);
                    chk("ena_off_busy", 32'(busy), 1);
                end
                if (mode == 4 && rd_seen - rb >= 3) begin
                    #2 rst_n = 1'b0;
                    #1 check_zero("async_rst");
                    @(posedge clk);
                    #1 rst_n = 1'b1;
                    return;
                end
                cyc();
                nw = wlog.size() - wb;
                case (mode)
                    1: begin
                        force_full  = $urandom_range(3) == 0;
                        force_empty = $urandom_range(3) == 0;
                        ena         = $urandom_range(7) != 0;
                    end
                    2: if (nw >= 2 && hc < 10) begin force_full = 1'b1; hc++; end else force_full = 1'b0;
                    3: begin
                        start = nw < 2;
                        seed  = (nw < 2) ? ~sd : sd;
                        if (rd_seen - rb >= 1 && hc < 5) begin ena = 1'b0; hc++; end else ena = 1'b1;
                    end
                    default: ;
                endcase
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(got), 1);
        chk("pass", 32'(pass), 32'(ec == 0));
        chk("err_count", 32'(err_count), 32'(ec));
        chk("timeout", 32'(timeout), 0);
        chk("busy_in_done", 32'(busy), 0);
        cyc();
        ena = 1'b1; force_full = 1'b0; force_empty = 1'b0; start = 1'b0; seed = sd;
        @(negedge clk);
        if (mode != 1) chk("done_one_cycle", 32'(done), 0);
        else if (done) begin cyc(); @(negedge clk); end
        chk("idle_after_done", 32'(busy | done), 0);
        chk("pass_held", 32'(pass), 32'(ec == 0));
        if (mode != 1) chk("done_pulses", done_cnt - db, 1);
        nw = wlog.size() - wb;
        chk("wr_count", nw, n);
        for (int k = 0; k < n && k < nw; k++) begin
            e = sd + 8'(k);
            chk("wr_data", 32'(wlog[wb+k]), 32'(e));
        end
        if (mode == 0 && nw >= n) chk("wr_back_to_back", wcyc[wb+n-1] - wcyc[wb], n - 1);
        chk("fifo_drained", fcnt, 0);
    endtask

    initial begin
        int t8c;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; start8 = 1'b0; burst_len = 4'd0; seed = 8'h00;
        force_full = 1'b0; force_empty = 1'b0; cmask = 16'h0; pop_base = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        cyc();
        rst_n = 1'b1;
        burst(4, 8'h10, 16'h0000, 0);
        burst(0, 8'hFE, 16'h0000, 0);
        burst(4, 8'h10, 16'h0002, 0);
        burst(0, 8'h5A, 16'hFFFF, 0);
        burst(8, 8'h20, 16'h0000, 2);
        cyc();
        start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        t8c = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            t8c++;
            chk("t8_no_wr", 32'(wr_en8), 0);
            if (done8) break;
        end
        chk("t8_stall_cycles", t8c, 9);
        chk("t8_timeout", 32'(timeout8), 1);
        chk("t8_pass", 32'(pass8), 0);
        chk("t8_err", 32'(err_count8), 0);
        cyc();
        @(negedge clk);
        chk("t8_done_once", 32'(done8), 0);
        chk("t8_timeout_held", 32'(timeout8), 1);
        burst(6, 8'h40, 16'h0000, 3);
        burst(6, 8'h40, 16'h0001, 3);
        burst(8, 8'h33, 16'h0001, 4);
        burst(5, 8'hA0, 16'h0000, 0);
        repeat (10) burst(int'($urandom_range(15)), 8'($urandom), 16'($urandom & $urandom & $urandom), 1);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
